// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced level into one-clock event pulses.
//
// Purpose
//   Turns a debounced button level into one-clock pulses for press, release,
//   short click, long press and auto-repeat while held. All timing is counted
//   in clken sample ticks.
//
// Ports
//   i_clk          system clock, all logic on posedge
//   i_rst          synchronous active-high reset, overrides i_clken
//   i_clken        sample tick, state advances only when 1
//   i_in           debounced button level, 1 = pressed
//   o_press        1-clk pulse, button went down
//   o_release      1-clk pulse, button went up
//   o_click        1-clk pulse, released before the long press fired
//   o_long_press   1-clk pulse, hold reached LONG_TICKS
//   o_repeat_pls   1-clk pulse, every REPEAT_TICKS after the long press
module button_event_decoder #(
    parameter int WIDTH        = 16,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clken,
    input  logic i_in,
    output logic o_press,
    output logic o_release,
    output logic o_click,
    output logic o_long_press,
    output logic o_repeat_pls
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG
    } state_t;

    localparam logic [WIDTH-1:0] LONG_LAST = WIDTH'(LONG_TICKS - 1);
    localparam logic [WIDTH-1:0] REP_LAST  = WIDTH'(REPEAT_TICKS - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    logic w_press;
    logic w_release;
    logic w_click;
    logic w_long;
    logic w_rep;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_long      = 1'b0;
        w_rep       = 1'b0;

        if (i_clken) begin
            case (r_state)
                S_IDLE: begin
                    if (i_in) begin
                        w_press     = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HELD;
                    end
                end
                S_HELD: begin
                    // A release always wins over a long press on the same tick
                    if (!i_in) begin
                        w_release   = 1'b1;
                        w_click     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == LONG_LAST) begin
                        w_long      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_LONG;
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                S_LONG: begin
                    if (!i_in) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (REPEAT_EN && (r_cnt == REP_LAST)) begin
                        w_rep     = 1'b1;
                        w_cnt_nxt = '0;
                    end else if (r_cnt != REP_LAST) begin
                        // Without repeat the counter parks at REP_LAST
                        w_cnt_nxt = r_cnt + ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            o_press      <= 1'b0;
            o_release    <= 1'b0;
            o_click      <= 1'b0;
            o_long_press <= 1'b0;
            o_repeat_pls <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            o_press      <= w_press;
            o_release    <= w_release;
            o_click      <= w_click;
            o_long_press <= w_long;
            o_repeat_pls <= w_rep;
        end
    end

endmodule
